// File: rtl/zap_mem_arbiter_pkg.sv
// Shared definitions for the zap memory arbiter: FSM state encoding and bus constants.
package zap_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_D = 2'd1,
        ARB_SERVE_I = 2'd2,
        ARB_DONE    = 2'd3
    } arb_state_t;

    localparam logic [3:0] BEN_ALL = 4'hF;

endpackage

// File: rtl/zap_mem_arbiter_starve_ctr.sv
// Saturating count of D grants made while I waits; raises force_i once I has waited long enough.
// Only compiled when ZAP_ARB_FAIRNESS_EN is defined.
`ifdef ZAP_ARB_FAIRNESS_EN
module zap_mem_arbiter_starve_ctr #(
    parameter int MAX_D_GRANTS = 4,
    parameter int CNT_W        = $clog2(MAX_D_GRANTS + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_grant,
    input  logic i_grant,
    input  logic i_pending,
    output logic force_i
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_GRANTS);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (i_grant) begin
            cnt <= '0;
        end else if (d_grant && i_pending && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign force_i = i_pending && (cnt == CNT_MAX);

endmodule
`endif

// File: rtl/zap_mem_arbiter.sv
// Merges the core's I-RAM (read-only) and D-RAM ports onto one external bus, one transaction at a time.
// Define ZAP_ARB_FAIRNESS_EN to bound how long I can be starved by back-to-back D traffic.
module zap_mem_arbiter
    import zap_mem_arbiter_pkg::*;
#(
    parameter int MAX_D_GRANTS = 4,
    parameter int CNT_W        = $clog2(MAX_D_GRANTS + 1)
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_iram_rd_en,
    input  logic [31:0] i_iram_addr,
    output logic [31:0] o_iram_data,
    output logic        o_iram_stall,
    input  logic        i_dram_rd_en,
    input  logic        i_dram_wr_en,
    input  logic [31:0] i_dram_addr,
    input  logic [31:0] i_dram_data,
    input  logic [3:0]  i_dram_ben,
    output logic [31:0] o_dram_data,
    output logic        o_dram_stall,
    output logic        o_mem_rd_en,
    output logic        o_mem_wr_en,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_data,
    output logic [3:0]  o_mem_ben,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_stall
);

    arb_state_t state, state_next;
    logic       done_d, done_i;
    logic       d_req, i_req, force_i;
    logic       grant_d, grant_i, bus_done;

    assign d_req    = i_dram_rd_en | i_dram_wr_en;
    assign i_req    = i_iram_rd_en;
    assign bus_done = ~i_mem_stall;

`ifdef ZAP_ARB_FAIRNESS_EN
    zap_mem_arbiter_starve_ctr #(
        .MAX_D_GRANTS (MAX_D_GRANTS),
        .CNT_W        (CNT_W)
    ) u_starve_ctr (
        .clk       (i_clk),
        .reset_n   (i_reset_n),
        .d_grant   (grant_d),
        .i_grant   (grant_i),
        .i_pending (i_req),
        .force_i   (force_i)
    );
`else
    logic [CNT_W-1:0] unused_max;
    assign unused_max = CNT_W'(MAX_D_GRANTS);
    assign force_i    = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE never grants: the finished requester still presents its old request this cycle.
    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (i_req && (force_i || !d_req)) begin
                    grant_i    = 1'b1;
                    state_next = ARB_SERVE_I;
                end else if (d_req) begin
                    grant_d    = 1'b1;
                    state_next = ARB_SERVE_D;
                end
            end
            ARB_SERVE_D: if (bus_done) state_next = ARB_DONE;
            ARB_SERVE_I: if (bus_done) state_next = ARB_DONE;
            ARB_DONE:    state_next = ARB_IDLE;
            default:     state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_mem_rd_en <= 1'b0;
            o_mem_wr_en <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_data  <= '0;
            o_mem_ben   <= '0;
            o_iram_data <= '0;
            o_dram_data <= '0;
            done_d      <= 1'b0;
            done_i      <= 1'b0;
        end else begin
            done_d <= 1'b0;
            done_i <= 1'b0;
            if (grant_d) begin
                o_mem_rd_en <= ~i_dram_wr_en;
                o_mem_wr_en <= i_dram_wr_en;
                o_mem_addr  <= i_dram_addr;
                o_mem_data  <= i_dram_wr_en ? i_dram_data : '0;
                o_mem_ben   <= i_dram_wr_en ? i_dram_ben : BEN_ALL;
            end else if (grant_i) begin
                o_mem_rd_en <= 1'b1;
                o_mem_wr_en <= 1'b0;
                o_mem_addr  <= i_iram_addr;
                o_mem_data  <= '0;
                o_mem_ben   <= BEN_ALL;
            end
            if (state == ARB_SERVE_D && bus_done) begin
                o_mem_rd_en <= 1'b0;
                o_mem_wr_en <= 1'b0;
                done_d      <= 1'b1;
                if (o_mem_rd_en) o_dram_data <= i_mem_data;
            end
            if (state == ARB_SERVE_I && bus_done) begin
                o_mem_rd_en <= 1'b0;
                o_mem_wr_en <= 1'b0;
                done_i      <= 1'b1;
                o_iram_data <= i_mem_data;
            end
        end
    end

    // Stalls depend only on the request and our own state, never on the bus inputs.
    assign o_iram_stall = i_reset_n & i_req & ~((state == ARB_DONE) & done_i);
    assign o_dram_stall = i_reset_n & d_req & ~((state == ARB_DONE) & done_d);

endmodule
